avalon_key_responder: RTL and testbench
=======================================

Name: avalon_key_responder

Overview:
- Avalon-MM responder that gives the Nios II processor debounced pushbutton state, sticky press flags, per-key press counts and a level interrupt.
- Sits inside the Nios system, between the raw active-low KEY pins and the processor data bus.
- Replaces the plain input PIO for the KEY[3:1] buttons.

Parameters:
- WIDTH, 3, number of keys (1..4).
- DEBOUNCE_CYCLES, 50000, clocks a raw level must hold before it is accepted (1 ms at 50 MHz). Minimum 2.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- key_n  input  WIDTH  raw pushbuttons, asynchronous; 0 = pressed.
- avs_address  input  2  word address.
- avs_read  input  1  read strobe.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data.
- avs_readdata  output  32  read data, registered.
- avs_readdatavalid  output  1  one-cycle pulse qualifying avs_readdata.
- irq  output  1  level interrupt to the CPU.

Behaviour:
- Reset: all registers clear asynchronously on reset_n low.
  - Synchronizer flops reset to 1 (released).
  - stable = 0, edge = 0, mask = 0, all counters = 0.
  - avs_readdata = 0, avs_readdatavalid = 0, irq = 0.
- Synchronizer: two flops per key on key_n, then inverted, so sync = 1 means pressed.
- Debounce, independent per key:
  - Counter of width clog2(DEBOUNCE_CYCLES).
  - If sync == stable: counter is held at 0.
  - Otherwise the counter increments each cycle.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1, stable <= sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES consecutive cycles never changes stable.
  - Input-to-stable latency = 2 + DEBOUNCE_CYCLES cycles.
- Press event: one-cycle pulse when stable goes 0->1. Releases (1->0) generate no event.
- On each press event:
  - edge[i] <= 1.
  - presses[i] <= presses[i]+1. 8-bit counter, wraps 255 -> 0.
- Register map (bits above the listed fields read 0):
  - addr 0 DATA, RO: bits[WIDTH-1:0] = stable.
  - addr 1 MASK, RW: bits[WIDTH-1:0] = interrupt mask.
  - addr 2 EDGE, W1C: bits[WIDTH-1:0] = sticky press flags. Writing 1 clears that bit; writing 0 has no effect.
  - addr 3 COUNT: byte i = presses[i]. Any write clears all counters.
- Writes take effect at the clock edge where avs_write = 1. There is no waitrequest; the block always accepts.
- Reads:
  - Fixed latency 1: avs_read at edge N gives avs_readdatavalid = 1 and avs_readdata valid at edge N+1.
  - avs_readdata holds its value until the next read.
  - Read data reflects register contents before any same-cycle update.
- avs_read and avs_write both high: the write is performed, no readdatavalid is produced, and the read is dropped.
- Simultaneous set and clear:
  - A press event in the same cycle as a W1C on that bit leaves edge = 1 (set wins).
  - A press event in the same cycle as a COUNT write leaves that counter at 1; the others go to 0.
- irq = |(edge & mask), registered (one cycle after edge/mask change). It stays high until the flags are cleared or masked.
- Reset mid-debounce: counters are discarded. After release of reset a held key must re-qualify for the full 2 + DEBOUNCE_CYCLES cycles and then produces a press event.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=3):
- Reset, read addr 0..3 -> each returns 0x0 with avs_readdatavalid exactly 1 cycle after avs_read; irq = 0.
- Hold key_n=3'b110 -> DATA reads 0x1 after 6 cycles; EDGE reads 0x1; COUNT reads 0x000001. Release -> DATA 0x0, EDGE still 0x1.
- 3-cycle low glitch on key_n[1] -> DATA, EDGE and COUNT unchanged (0x0).
- Write MASK=0x2, then press key 1 -> irq rises one cycle after EDGE bit 1 sets. Write EDGE=0x2 -> irq falls next cycle. Write EDGE=0x0 -> no effect.
- Press key 2 256 times, then once more -> COUNT byte 2 reads 0x00, then 0x01. Write addr 3 in the same cycle as a key 0 press event -> COUNT = 0x000001.
- Pulse reset_n low while key 0 is held mid-debounce -> all registers 0 immediately; after release, DATA reads 0x1 exactly 6 cycles later with EDGE = 0x1.

Source files
------------

// File: rtl/avalon_key_responder.sv
// Avalon-MM pushbutton responder for the Nios II system.
// It synchronizes and debounces the active-low KEY pins and keeps a sticky
// press flag and an 8-bit press counter for each key. A read port exposes
// these values, and an interrupt output is driven by the masked press flags.
module avalon_key_responder #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_n,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  output logic             irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LP_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LP_CNT_ONE = CW'(1);

  localparam logic [1:0] LP_ADDR_DATA  = 2'd0;
  localparam logic [1:0] LP_ADDR_MASK  = 2'd1;
  localparam logic [1:0] LP_ADDR_EDGE  = 2'd2;
  localparam logic [1:0] LP_ADDR_COUNT = 2'd3;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_db_cnt [WIDTH];
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [7:0]       r_presses [WIDTH];

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_press;
  logic [WIDTH-1:0] w_edge_clr;
  logic             w_wr_mask;
  logic             w_wr_edge;
  logic             w_wr_count;
  logic             w_rd;
  logic [31:0]      w_rdata;
  logic             w_unused_wdata;

  // The high write-data bits have no register behind them.
  assign w_unused_wdata = ^avs_writedata[31:WIDTH];

  assign w_sync     = ~r_sync2;
  assign w_wr_mask  = avs_write && (avs_address == LP_ADDR_MASK);
  assign w_wr_edge  = avs_write && (avs_address == LP_ADDR_EDGE);
  assign w_wr_count = avs_write && (avs_address == LP_ADDR_COUNT);
  // When a read and a write arrive together, the read is dropped.
  assign w_rd       = avs_read && !avs_write;
  assign w_edge_clr = w_wr_edge ? avs_writedata[WIDTH-1:0] : '0;

  // Two-flop synchronizer. It resets to the released level (pins high).
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  // A press event fires on the cycle a pressed level finishes qualifying.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch can be inferred.
    w_press = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_press[i] = w_sync[i] && !r_stable[i] && (r_db_cnt[i] == LP_CNT_MAX);
    end
  end

  // Per-key debounce. The counter runs only while the synchronized input
  // disagrees with the accepted level.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the counter and flag arrays are reset explicitly, because a reset in the middle of debouncing must discard the partial count.
    if (!reset_n) begin
      r_stable <= '0;
      for (int i = 0; i < WIDTH; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_sync[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == LP_CNT_MAX) begin
          r_stable[i] <= w_sync[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + LP_CNT_ONE;
        end
      end
    end
  end

  // Mask register, sticky press flags (set wins over W1C), and press counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_edge <= '0;
      for (int i = 0; i < WIDTH; i++) r_presses[i] <= '0;
    end else begin
      if (w_wr_mask) r_mask <= avs_writedata[WIDTH-1:0];
      r_edge <= (r_edge & ~w_edge_clr) | w_press;
      for (int i = 0; i < WIDTH; i++) begin
        if (w_wr_count) begin
          r_presses[i] <= {7'd0, w_press[i]};
        end else if (w_press[i]) begin
          r_presses[i] <= r_presses[i] + 8'd1;
        end
      end
    end
  end

  // Read mux over the pre-update register contents.
  always_comb begin
    w_rdata = '0;
    case (avs_address)
      LP_ADDR_DATA: w_rdata[WIDTH-1:0] = r_stable;
      LP_ADDR_MASK: w_rdata[WIDTH-1:0] = r_mask;
      LP_ADDR_EDGE: w_rdata[WIDTH-1:0] = r_edge;
      default: begin
        for (int i = 0; i < WIDTH; i++) w_rdata[8*i +: 8] = r_presses[i];
      end
    endcase
  end

  // Read data is registered with a fixed latency of 1. It holds between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= w_rd;
      if (w_rd) avs_readdata <= w_rdata;
    end
  end

  // Level interrupt, registered one cycle behind the flag and mask state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(r_edge & r_mask);
  end

endmodule

// File: tb/tb_avalon_key_responder.sv
// Bench for avalon_key_responder (WIDTH=3, DEBOUNCE_CYCLES=4).
// It runs a directed sequence and then a randomized phase. Both are compared
// every cycle against a window-based behavioural reference model.
module tb_avalon_key_responder;

  localparam int W = 3;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] key_n;
  logic [1:0]   avs_address;
  logic         avs_read;
  logic         avs_write;
  logic [31:0]  avs_writedata;
  logic [31:0]  avs_readdata;
  logic         avs_readdatavalid;
  logic         irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_stable, m_mask, m_edge;
  logic [7:0]   m_presses [W];
  logic         m_irq, m_rvalid;
  logic [31:0]  m_rdata;
  logic [W-1:0] hist [$];   // pressed-level samples, newest first

  avalon_key_responder #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset_n(reset_n), .key_n(key_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_value(input logic [1:0] a);
    case (a)
      2'd0:    reg_value = {29'd0, m_stable};
      2'd1:    reg_value = {29'd0, m_mask};
      2'd2:    reg_value = {29'd0, m_edge};
      default: reg_value = {8'd0, m_presses[2], m_presses[1], m_presses[0]};
    endcase
  endfunction

  task automatic model_reset();
    m_stable = '0; m_mask = '0; m_edge = '0;
    m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    for (int i = 0; i < W; i++) m_presses[i] = '0;
    hist.delete();
    for (int j = 0; j < D + 1; j++) hist.push_back('0);
  endtask

  // One clock edge of the specified behaviour. A key's accepted level flips
  // once the D samples that sit two synchronizer stages behind the pin all
  // disagree with it.
  task automatic model_step();
    logic [W-1:0] press;
    logic         all_diff;
    logic         new_irq;
    new_irq = |(m_edge & m_mask);
    if (avs_read && !avs_write) begin
      m_rvalid = 1'b1;
      m_rdata  = reg_value(avs_address);
    end else begin
      m_rvalid = 1'b0;
    end
    m_irq = new_irq;
    hist.push_front(~key_n);
    press = '0;
    for (int i = 0; i < W; i++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= D + 1; j++) if (hist[j][i] == m_stable[i]) all_diff = 1'b0;
      if (all_diff) begin
        if (!m_stable[i]) press[i] = 1'b1;
        m_stable[i] = ~m_stable[i];
      end
    end
    void'(hist.pop_back());
    if (avs_write) begin
      case (avs_address)
        2'd1: m_mask = avs_writedata[W-1:0];
        2'd2: m_edge = m_edge & ~avs_writedata[W-1:0];
        2'd3: for (int i = 0; i < W; i++) m_presses[i] = '0;
        default: ;
      endcase
    end
    m_edge = m_edge | press;
    for (int i = 0; i < W; i++) if (press[i]) m_presses[i] = m_presses[i] + 8'd1;
  endtask

  // Advance one cycle, then compare all outputs on the falling edge.
  task automatic step();
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_step();
    @(negedge clk);
    check("rvalid", {31'd0, avs_readdatavalid}, {31'd0, m_rvalid});
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    check("rdata", avs_readdata, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    step();
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    step();
    avs_read = 1'b0;
    check("rd_valid_lat1", {31'd0, avs_readdatavalid}, 32'd1);
    d = avs_readdata;
  endtask

  task automatic press_key(input int k);
    key_n[k] = 1'b0; idle(D + 2);
    key_n[k] = 1'b1; idle(D + 2);
  endtask

  logic [31:0] rd;
  int r;

  initial begin
    reset_n = 1'b0; key_n = '1; avs_address = '0;
    avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    model_reset();
    idle(2);
    reset_n = 1'b1;
    idle(1);

    // Reset state of every register
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      check("reset_reg", rd, 32'h0);
    end
    check("reset_irq", {31'd0, irq}, 32'd0);

    // Key 0 press: accepted exactly 2 + D cycles after the pin changes
    key_n = 3'b110;
    idle(D + 1);
    bus_read(2'd0, rd); check("data_before_lat", rd, 32'h0);
    bus_read(2'd0, rd); check("data_after_lat", rd, 32'h1);
    bus_read(2'd2, rd); check("edge_k0", rd, 32'h1);
    bus_read(2'd3, rd); check("count_k0", rd, 32'h000001);
    key_n = 3'b111;
    idle(D + 2);
    bus_read(2'd0, rd); check("data_release", rd, 32'h0);
    bus_read(2'd2, rd); check("edge_sticky", rd, 32'h1);

    // A glitch of D-1 cycles changes nothing
    bus_write(2'd2, 32'h7);
    bus_write(2'd3, 32'h0);
    key_n[1] = 1'b0; idle(D - 1);
    key_n[1] = 1'b1; idle(D + 4);
    bus_read(2'd0, rd); check("glitch_data", rd, 32'h0);
    bus_read(2'd2, rd); check("glitch_edge", rd, 32'h0);
    bus_read(2'd3, rd); check("glitch_count", rd, 32'h0);

    // The interrupt follows the masked flags with one cycle of delay
    bus_write(2'd1, 32'h2);
    key_n[1] = 1'b0;
    idle(D + 2);
    check("irq_not_yet", {31'd0, irq}, 32'd0);
    step();
    check("irq_rise", {31'd0, irq}, 32'd1);
    key_n[1] = 1'b1;
    bus_write(2'd2, 32'h0);
    check("w1c_zero_irq", {31'd0, irq}, 32'd1);
    bus_read(2'd2, rd); check("w1c_zero_edge", rd, 32'h2);
    bus_write(2'd2, 32'h2);
    check("irq_lag", {31'd0, irq}, 32'd1);
    step();
    check("irq_fall", {31'd0, irq}, 32'd0);
    idle(D + 2);

    // The 8-bit counter wraps at 256 presses
    bus_write(2'd3, 32'h0);
    for (int n = 0; n < 256; n++) press_key(2);
    bus_read(2'd3, rd); check("count_wrap", rd, 32'h000000);
    press_key(2);
    bus_read(2'd3, rd); check("count_after_wrap", rd, 32'h010000);

    // A COUNT write in the same cycle as a press event
    key_n[0] = 1'b0; idle(D + 1);
    bus_write(2'd3, 32'hFFFF_FFFF);
    key_n[0] = 1'b1; idle(D + 2);
    bus_read(2'd3, rd); check("count_clr_vs_press", rd, 32'h000001);

    // A W1C on EDGE in the same cycle as a press event (set wins)
    key_n[0] = 1'b0; idle(D + 1);
    bus_write(2'd2, 32'h1);
    key_n[0] = 1'b1; idle(D + 2);
    bus_read(2'd2, rd); check("edge_set_wins", rd, 32'h5);
    bus_write(2'd2, 32'h7);

    // Reset in the middle of debouncing
    key_n[0] = 1'b0; idle(D - 1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_rdata", avs_readdata, 32'h0);
    check("rst_async_rvalid", {31'd0, avs_readdatavalid}, 32'd0);
    check("rst_async_irq", {31'd0, irq}, 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(D + 1);
    bus_read(2'd0, rd); check("requal_before", rd, 32'h0);
    bus_read(2'd0, rd); check("requal_data", rd, 32'h1);
    bus_read(2'd2, rd); check("requal_edge", rd, 32'h1);
    bus_read(2'd1, rd); check("requal_mask", rd, 32'h0);
    key_n = '1; idle(D + 2);

    // Randomized phase, checked every cycle against the model
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        r = int'($urandom_range(0, W - 1));
        key_n[r] = ~key_n[r];
      end
      r = int'($urandom_range(0, 9));
      avs_address   = 2'($urandom_range(0, 3));
      avs_writedata = $urandom;
      avs_read      = (r <= 3) || (r == 6);
      avs_write     = (r == 4) || (r == 5) || (r == 6);
      step();
    end
    avs_read = 1'b0; avs_write = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
